seq_mult_param: RTL and testbench
=================================

SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand width in bits; legal values are 2..32.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port rst, input, 1, asynchronous active-high reset.
REQ-004 Port start, input, 1, requests a multiply; sampled on the rising clk edge.
REQ-005 Port signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned; sampled together with start.
REQ-006 Port op_a, input, WIDTH, multiplicand; sampled together with start.
REQ-007 Port op_b, input, WIDTH, multiplier; sampled together with start.
REQ-008 Port busy, output, 1, high while a multiply is in progress.
REQ-009 Port done, output, 1, single-cycle pulse marking product valid.
REQ-010 Port product, output, 2*WIDTH, registered result; held until the next accepted start.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 A start SHALL be accepted only in IDLE or DONE; on that edge the block latches the operand magnitudes, the result sign and mode, clears the accumulator and iteration counter, and enters RUN.
REQ-013 In RUN, each clock SHALL examine the multiplier LSB, conditionally add the multiplicand magnitude into the accumulator's upper half, shift the accumulator/multiplier right by one, and increment the counter.
REQ-014 After exactly WIDTH RUN iterations, the FSM SHALL write the product (negated when signed_mode=1 and operand signs differ) and enter DONE.
REQ-015 done SHALL be high for exactly one cycle, WIDTH+1 cycles after the accepting edge; product SHALL be valid in that same cycle.
REQ-016 From DONE, the FSM SHALL return to IDLE on the next edge unless start=1; start=1 in DONE SHALL begin a new multiply back-to-back.
REQ-017 busy SHALL be 1 exactly in RUN.
REQ-018 start asserted while in RUN SHALL be ignored, with no effect on operands or timing.
REQ-019 In signed mode, magnitudes SHALL be WIDTH-bit unsigned so that the most-negative operand is handled correctly (e.g. -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2)).
REQ-020 The accumulator SHALL be 2*WIDTH+1 bits internally, so no overflow or carry is lost; product is the low 2*WIDTH bits.
REQ-021 Operand inputs SHALL be don't-care except on the accepting edge.

Reset
REQ-022 rst SHALL asynchronously force the IDLE state, busy=0, done=0, product=0, and clear the counter and accumulator.
REQ-023 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the default WIDTH, and the counter-width function clog2(WIDTH+1).
REQ-025 A sub-module mult_sign_fix SHALL perform the combinational absolute-value of each operand and the conditional two's-complement negation of the product; the FSM and shift/add datapath remain in the top.

Verification
REQ-026 WIDTH=4, unsigned, 15*15, start pulse -> busy for 4 cycles, done at cycle 5, product 0xE1 (225).
REQ-027 WIDTH=4, signed, -8*7 -> product 0xC8 (-56); signed -8*-8 -> product 0x40 (64).
REQ-028 WIDTH=8, signed, 0x80*0x01 -> product 0xFF80; unsigned 0xFF*0xFF -> product 0xFE01; 0*0xA5 -> product 0x0000.
REQ-029 WIDTH=8, start re-pulsed with new operands during RUN -> ignored; first product unchanged, done still at cycle 9.
REQ-030 WIDTH=8, rst asserted at RUN cycle 3 -> busy, done and product equal 0 immediately with no done pulse; a subsequent 12*13 -> product 156.
REQ-031 Back-to-back: start held high in the DONE cycle with 3*5 after 7*9 -> products 63 then 15, with done pulses 9 cycles apart (WIDTH=8).

Source files
------------

// File: rtl/seq_mult_param_pkg.sv
// Shared types and sizing helpers for the sequential multiplier.
// Holds the FSM encoding, the default operand width and the counter width.
package seq_mult_param_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Sign handling around the unsigned shift/add core.
// Produces operand magnitudes, the result sign and the sign-corrected product.
module mult_sign_fix #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic               signed_mode,
   input  logic               neg_in,
   input  logic [2*WIDTH-1:0] raw,
   output logic [WIDTH-1:0]   mag_a,
   output logic [WIDTH-1:0]   mag_b,
   output logic               neg_res,
   output logic [2*WIDTH-1:0] fixed
);

   logic a_neg;
   logic b_neg;

   // Magnitudes stay WIDTH-bit unsigned so the most-negative value maps cleanly.
   always_comb begin
      a_neg   = signed_mode & op_a[WIDTH-1];
      b_neg   = signed_mode & op_b[WIDTH-1];
      mag_a   = a_neg ? -op_a : op_a;
      mag_b   = b_neg ? -op_b : op_b;
      neg_res = a_neg ^ b_neg;
      fixed   = neg_in ? -raw : raw;
   end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift/add multiplier, one multiplier bit per clock.
// IDLE/RUN/DONE control; signed operands handled via magnitudes and final negation.
module seq_mult_param
   import seq_mult_param_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = cnt_width(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   mag_a_q;
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH:0]   acc_step;
   logic [WIDTH:0]     upper;
   logic [CW-1:0]      cnt;
   logic               neg_q;
   logic               accept;
   logic               last;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               neg_res;
   logic [2*WIDTH-1:0] fixed;

   mult_sign_fix #(
      .WIDTH(WIDTH)
   ) u_sign_fix (
      .op_a       (op_a),
      .op_b       (op_b),
      .signed_mode(signed_mode),
      .neg_in     (neg_q),
      .raw        (acc_step[2*WIDTH-1:0]),
      .mag_a      (mag_a),
      .mag_b      (mag_b),
      .neg_res    (neg_res),
      .fixed      (fixed)
   );

   // One shift/add step: add multiplicand to the upper half on LSB=1, then shift.
   always_comb begin
      upper    = acc[2*WIDTH:WIDTH];
      if (acc[0]) begin
         upper = upper + {1'b0, mag_a_q};
      end
      acc_step = {1'b0, upper, acc[WIDTH-1:1]};
      accept   = start && (state != S_RUN);
      last     = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = start ? S_RUN : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: latch operands on accept, iterate in RUN, write product on last step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mag_a_q <= '0;
         acc     <= '0;
         cnt     <= '0;
         neg_q   <= 1'b0;
         product <= '0;
      end else if (accept) begin
         mag_a_q <= mag_a;
         acc     <= {{(WIDTH + 1){1'b0}}, mag_b};
         cnt     <= '0;
         neg_q   <= neg_res;
      end else if (state == S_RUN) begin
         acc <= acc_step;
         cnt <= cnt + CW'(1);
         if (last) begin
            product <= fixed;
         end
      end
   end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param at WIDTH=4 and WIDTH=8.
// Expected products come from an integer model through per-width scoreboards.
module tb_seq_mult_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        s4, sm4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic        s8, sm8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  q4[$];
   logic [15:0] q8[$];

   always #5 clk = ~clk;

   seq_mult_param #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .start(s4), .signed_mode(sm4),
      .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .product(p4)
   );

   seq_mult_param #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8),
      .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .product(p8)
   );

   function automatic logic [63:0] model(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input bit sm, input int w);
      longint sa, sb, p;
      sa = longint'(a);
      sb = longint'(b);
      if (sm && a[w-1]) sa = sa - (longint'(1) << w);
      if (sm && b[w-1]) sb = sb - (longint'(1) << w);
      p = sa * sb;
      return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // Drive one start at a negedge, scramble operands afterwards, wait for done.
   task automatic go4(input logic [3:0] a, input logic [3:0] b, input bit sm,
                      output int lat, output int nbusy);
      logic [63:0] m;
      m = model(32'(a), 32'(b), sm, 4);
      q4.push_back(m[7:0]);
      s4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
      lat = 0; nbusy = 0;
      do begin
         @(negedge clk);
         s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
         lat++;
         if (busy4) nbusy++;
      end while (!done4 && lat < 40);
   endtask

   task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                      output int lat, output int nbusy);
      logic [63:0] m;
      m = model(32'(a), 32'(b), sm, 8);
      q8.push_back(m[15:0]);
      s8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
      lat = 0; nbusy = 0;
      do begin
         @(negedge clk);
         s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
         lat++;
         if (busy8) nbusy++;
      end while (!done8 && lat < 40);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s4 = 0; sm4 = 0; a4 = 0; b4 = 0;
      s8 = 0; sm8 = 0; a8 = 0; b8 = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || busy8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got %b/%b want 0/0", busy4, busy8);
      end
      checks++;
      if (done4 !== 1'b0 || done8 !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got %b/%b want 0/0", done4, done8);
      end
      checks++;
      if (p4 !== 8'h00 || p8 !== 16'h0000) begin
         failures++;
         $display("FAIL reset_product got %h/%h want 0/0", p4, p8);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned4();
      int lat, nb;
      logic [7:0] exp;
      go4(4'hF, 4'hF, 1'b0, lat, nb);
      exp = q4.pop_front();
      checks++;
      if (lat !== 5) begin
         failures++;
         $display("FAIL u4_done_cycle got %0d want 5", lat);
      end
      checks++;
      if (nb !== 4) begin
         failures++;
         $display("FAIL u4_busy_cycles got %0d want 4", nb);
      end
      checks++;
      if (p4 !== exp) begin
         failures++;
         $display("FAIL u4_product got %h want %h", p4, exp);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0 || p4 !== exp) begin
         failures++;
         $display("FAIL u4_after_done got d=%b b=%b p=%h want 0 0 %h",
                  done4, busy4, p4, exp);
      end
   endtask

   task automatic test_signed4();
      int lat, nb;
      logic [7:0] exp;
      logic [3:0] av[3];
      logic [3:0] bv[3];
      av = '{4'h8, 4'h8, 4'h3};
      bv = '{4'h7, 4'h8, 4'hB};
      for (int i = 0; i < 3; i++) begin
         go4(av[i], bv[i], 1'b1, lat, nb);
         exp = q4.pop_front();
         checks++;
         if (lat !== 5 || p4 !== exp) begin
            failures++;
            $display("FAIL s4_case%0d got lat=%0d p=%h want lat=5 p=%h",
                     i, lat, p4, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_width8();
      int lat, nb;
      logic [15:0] exp;
      logic [7:0] av[5];
      logic [7:0] bv[5];
      bit         mv[5];
      av = '{8'h80, 8'hFF, 8'h00, 8'h7F, 8'h80};
      bv = '{8'h01, 8'hFF, 8'hA5, 8'h81, 8'h80};
      mv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         go8(av[i], bv[i], mv[i], lat, nb);
         exp = q8.pop_front();
         checks++;
         if (lat !== 9 || nb !== 8) begin
            failures++;
            $display("FAIL w8_timing%0d got lat=%0d busy=%0d want 9 8", i, lat, nb);
         end
         checks++;
         if (p8 !== exp) begin
            failures++;
            $display("FAIL w8_product%0d got %h want %h", i, p8, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      logic [63:0] m;
      logic [15:0] exp;
      m = model(32'h12, 32'h34, 1'b0, 8);
      q8.push_back(m[15:0]);
      s8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 3) begin
            s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b1;
         end else begin
            s8 = 1'b0;
         end
      end while (!done8 && lat < 40);
      exp = q8.pop_front();
      checks++;
      if (lat !== 9) begin
         failures++;
         $display("FAIL ignore_done_cycle got %0d want 9", lat);
      end
      checks++;
      if (p8 !== exp) begin
         failures++;
         $display("FAIL ignore_product got %h want %h", p8, exp);
      end
      @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         failures++;
         $display("FAIL ignore_idle got b=%b d=%b want 0 0", busy8, done8);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat, nb, seen;
      logic [15:0] exp;
      s8 = 1'b1; a8 = 8'hAB; b8 = 8'hCD; sm8 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         s8 = 1'b0;
      end
      checks++;
      if (busy8 !== 1'b1) begin
         failures++;
         $display("FAIL abort_running got busy=%b want 1", busy8);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'h0000) begin
         failures++;
         $display("FAIL abort_clear got b=%b d=%b p=%h want 0 0 0000",
                  busy8, done8, p8);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL abort_no_done got %0d active cycles want 0", seen);
      end
      go8(8'd12, 8'd13, 1'b0, lat, nb);
      exp = q8.pop_front();
      checks++;
      if (lat !== 9 || p8 !== exp) begin
         failures++;
         $display("FAIL abort_restart got lat=%0d p=%h want 9 %h", lat, p8, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, nb;
      logic [15:0] exp;
      go8(8'd7, 8'd9, 1'b0, lat1, nb);
      exp = q8.pop_front();
      checks++;
      if (lat1 !== 9 || p8 !== exp) begin
         failures++;
         $display("FAIL b2b_first got lat=%0d p=%h want 9 %h", lat1, p8, exp);
      end
      go8(8'd3, 8'd5, 1'b0, lat2, nb);
      exp = q8.pop_front();
      checks++;
      if (lat2 !== 9) begin
         failures++;
         $display("FAIL b2b_spacing got %0d want 9", lat2);
      end
      checks++;
      if (p8 !== exp) begin
         failures++;
         $display("FAIL b2b_second got %h want %h", p8, exp);
      end
      @(negedge clk);
      checks++;
      if (q4.size() != 0 || q8.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left got %0d/%0d want 0/0", q4.size(), q8.size());
      end
   endtask

   initial begin
      test_reset();
      test_unsigned4();
      test_signed4();
      test_width8();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
